multicycle_control_unit: RTL and testbench

Moore/Mealy control FSM that sequences the RV32I multi-cycle datapath: shared instruction/data memory port, one ALU, PC, IR, OldPC, ALUOut and data registers. It replaces the single-cycle combinational decoder when the core is built with a shared memory and one ALU. It issues per-cycle mux selects and write strobes, and handshakes with memory through a req/ready pair. The alu_op encoding matches the existing single-cycle control unit, so the ALU decoder is reused unchanged.

---
 rtl/rv32_pkg.sv | 26 ++
 rtl/mcyc_opcode_class.sv | 16 +
 rtl/multicycle_control_unit.sv | 147 ++++++++++++++
 tb/tb_multicycle_control_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: opcodes, FSM states and datapath select encodings shared by the multi-cycle control unit.
// MCYC_JUMP_EN adds the JAL/JALR sequencing states.
package rv32_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_AUIPC, S_ALU_WB, S_MEM_ADR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_TRAP
`ifdef MCYC_JUMP_EN
        , S_JUMP, S_JALR_ADR
`endif
    } state_t;
    typedef enum logic [1:0] {A_PC = 2'b00, A_OLDPC = 2'b01, A_RS1 = 2'b10} alu_src_a_t;
    typedef enum logic [1:0] {B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10} alu_src_b_t;
    typedef enum logic [1:0] {ALU_FUNCT, ALU_ADD, ALU_OPIMM, ALU_BRANCH} alu_op_t;
    typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10} result_src_t;
    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_AUIPC, C_JAL, C_JALR, C_ILLEGAL
    } op_class_t;
endpackage

// File: rtl/mcyc_opcode_class.sv
// mcyc_opcode_class: classifies IR[6:0] into the instruction class that steers DECODE.
module mcyc_opcode_class
    import rv32_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [3:0] cls
);
    assign cls = opcode == OP_R      ? C_R      :
                 opcode == OP_I      ? C_I      :
                 opcode == OP_LOAD   ? C_LOAD   :
                 opcode == OP_STORE  ? C_STORE  :
                 opcode == OP_BRANCH ? C_BRANCH :
                 opcode == OP_AUIPC  ? C_AUIPC  :
                 opcode == OP_JAL    ? C_JAL    :
                 opcode == OP_JALR   ? C_JALR   : C_ILLEGAL;
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: sequences the shared-memory, single-ALU RV32I datapath.
// Define MCYC_JUMP_EN to decode JAL/JALR; otherwise they trap.
module multicycle_control_unit
    import rv32_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       retire,
    output logic       illegal
);
    state_t     state, next;
    logic [3:0] cls;

    mcyc_opcode_class u_class (.opcode(opcode), .cls(cls));

    always_ff @(posedge clk)
        state <= rst_n ? next : S_FETCH;

    // Outputs decode the current state; holding reset low silences everything in the same cycle.
    always_comb begin
        next       = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        alu_src_a  = A_PC;
        alu_src_b  = B_RS2;
        alu_op     = ALU_FUNCT;
        result_src = RES_ALUOUT;
        retire     = 1'b0;
        illegal    = 1'b0;
        if (rst_n)
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = B_FOUR;
                    alu_op     = ALU_ADD;
                    result_src = RES_ALU;
                    ir_we      = mem_ready;
                    pc_we      = mem_ready;
                    next       = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_a = A_OLDPC;
                    alu_src_b = B_IMM;
                    alu_op    = ALU_ADD;
                    case (cls)
                        C_R:      next = S_EXEC_R;
                        C_I:      next = S_EXEC_I;
                        C_LOAD:   next = S_MEM_ADR;
                        C_STORE:  next = S_MEM_ADR;
                        C_BRANCH: next = S_BRANCH;
                        C_AUIPC:  next = S_AUIPC;
`ifdef MCYC_JUMP_EN
                        C_JAL:    next = S_JUMP;
                        C_JALR:   next = S_JALR_ADR;
`endif
                        default:  next = S_TRAP;
                    endcase
                end
                S_EXEC_R: begin
                    alu_src_a = A_RS1;
                    next      = S_ALU_WB;
                end
                S_EXEC_I: begin
                    alu_src_a = A_RS1;
                    alu_src_b = B_IMM;
                    alu_op    = ALU_OPIMM;
                    next      = S_ALU_WB;
                end
                S_AUIPC: begin
                    alu_src_a = A_OLDPC;
                    alu_src_b = B_IMM;
                    alu_op    = ALU_ADD;
                    next      = S_ALU_WB;
                end
                S_ALU_WB: begin
                    reg_we = 1'b1;
                    retire = 1'b1;
                    next   = S_FETCH;
                end
                S_MEM_ADR: begin
                    alu_src_a = A_RS1;
                    alu_src_b = B_IMM;
                    alu_op    = ALU_ADD;
                    next      = cls == C_LOAD ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    next    = mem_ready ? S_MEM_WB : S_MEM_RD;
                end
                S_MEM_WB: begin
                    reg_we     = 1'b1;
                    result_src = RES_MEM;
                    retire     = 1'b1;
                    next       = S_FETCH;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    retire  = mem_ready;
                    next    = mem_ready ? S_FETCH : S_MEM_WR;
                end
                S_BRANCH: begin
                    alu_src_a = A_RS1;
                    alu_op    = ALU_BRANCH;
                    pc_we     = br_taken;
                    retire    = 1'b1;
                    next      = S_FETCH;
                end
`ifdef MCYC_JUMP_EN
                S_JALR_ADR: begin
                    alu_src_a = A_RS1;
                    alu_src_b = B_IMM;
                    alu_op    = ALU_ADD;
                    next      = S_JUMP;
                end
                S_JUMP: begin
                    alu_src_a = A_OLDPC;
                    alu_src_b = B_FOUR;
                    alu_op    = ALU_ADD;
                    pc_we     = 1'b1;
                    next      = S_ALU_WB;
                end
`endif
                S_TRAP: illegal = 1'b1;
                default: next = S_TRAP;
            endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: builds the expected per-cycle output script of each instruction
// from its class, wait counts and branch outcome, then replays it against the DUT.
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       rst_n, br_taken, mem_ready;
    logic [6:0] opcode;
    logic       mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, retire, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    int         checks = 0;
    int         fails  = 0;

    localparam logic [1:0] PC = 2'd0, OLD = 2'd1, RS1 = 2'd2;
    localparam logic [1:0] RS2 = 2'd0, IMM = 2'd1, FOUR = 2'd2;
    localparam logic [1:0] FN = 2'd0, ADD = 2'd1, OPI = 2'd2, BRC = 2'd3;
    localparam logic [1:0] AOUT = 2'd0, MEMD = 2'd1, ALUR = 2'd2;
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_AUI = 5, K_JAL = 6, K_JALR = 7;
    logic [6:0] ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                            7'b1100011, 7'b0010111, 7'b1101111, 7'b1100111};

    typedef struct {
        logic [15:0] e;
        logic        rdy;
        logic        bt;
        string       tag;
    } step_t;
    step_t q[$];

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_we(ir_we), .pc_we(pc_we),
        .reg_we(reg_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    wire [15:0] got = {mem_req, mem_we, adr_src, ir_we, pc_we, reg_we,
                       alu_src_a, alu_src_b, alu_op, result_src, retire, illegal};

    function automatic logic [15:0] ov(input logic req, we, adr, irw, pcw, rw,
                                       input logic [1:0] a, b, op, rs, input logic ret, ill);
        return {req, we, adr, irw, pcw, rw, a, b, op, rs, ret, ill};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input logic [15:0] e, input string tag);
        checks++;
        assert (got === e) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, e);
        end
    endtask

    task automatic push(input logic [15:0] e, input logic rdy, input logic bt, input string tag);
        q.push_back('{e: e, rdy: rdy, bt: bt, tag: tag});
    endtask

    // Replays the script: inputs driven 1 time unit after the edge, outputs compared 3 units later.
    task automatic play();
        foreach (q[i]) begin
            mem_ready = q[i].rdy;
            br_taken  = q[i].bt;
            #3;
            chk(q[i].e, q[i].tag);
            @(posedge clk);
            #1;
        end
        q.delete();
    endtask

    task automatic fetch(input int waits);
        for (int i = 0; i < waits; i++)
            push(ov(1, 0, 0, 0, 0, 0, PC, FOUR, ADD, ALUR, 0, 0), 1'b0, rnd(), "fetch_wait");
        push(ov(1, 0, 0, 1, 1, 0, PC, FOUR, ADD, ALUR, 0, 0), 1'b1, rnd(), "fetch");
        push(ov(0, 0, 0, 0, 0, 0, OLD, IMM, ADD, AOUT, 0, 0), rnd(), rnd(), "decode");
    endtask

    task automatic writeback();
        push(ov(0, 0, 0, 0, 0, 1, PC, RS2, FN, AOUT, 1, 0), rnd(), rnd(), "alu_wb");
    endtask

    task automatic instr(input int k, input int fw, input int mw, input logic bt);
        opcode = ops[k];
        fetch(fw);
        case (k)
            K_R: begin
                push(ov(0, 0, 0, 0, 0, 0, RS1, RS2, FN, AOUT, 0, 0), rnd(), rnd(), "exec_r");
                writeback();
            end
            K_I: begin
                push(ov(0, 0, 0, 0, 0, 0, RS1, IMM, OPI, AOUT, 0, 0), rnd(), rnd(), "exec_i");
                writeback();
            end
            K_AUI: begin
                push(ov(0, 0, 0, 0, 0, 0, OLD, IMM, ADD, AOUT, 0, 0), rnd(), rnd(), "auipc");
                writeback();
            end
            K_LD: begin
                push(ov(0, 0, 0, 0, 0, 0, RS1, IMM, ADD, AOUT, 0, 0), rnd(), rnd(), "mem_adr");
                for (int i = 0; i < mw; i++)
                    push(ov(1, 0, 1, 0, 0, 0, PC, RS2, FN, AOUT, 0, 0), 1'b0, rnd(), "mem_rd_wait");
                push(ov(1, 0, 1, 0, 0, 0, PC, RS2, FN, AOUT, 0, 0), 1'b1, rnd(), "mem_rd");
                push(ov(0, 0, 0, 0, 0, 1, PC, RS2, FN, MEMD, 1, 0), rnd(), rnd(), "mem_wb");
            end
            K_ST: begin
                push(ov(0, 0, 0, 0, 0, 0, RS1, IMM, ADD, AOUT, 0, 0), rnd(), rnd(), "mem_adr");
                for (int i = 0; i < mw; i++)
                    push(ov(1, 1, 1, 0, 0, 0, PC, RS2, FN, AOUT, 0, 0), 1'b0, rnd(), "mem_wr_wait");
                push(ov(1, 1, 1, 0, 0, 0, PC, RS2, FN, AOUT, 1, 0), 1'b1, rnd(), "mem_wr");
            end
            K_BR: push(ov(0, 0, 0, 0, bt, 0, RS1, RS2, BRC, AOUT, 1, 0), rnd(), bt, "branch");
            K_JAL, K_JALR: begin
                if (k == K_JALR)
                    push(ov(0, 0, 0, 0, 0, 0, RS1, IMM, ADD, AOUT, 0, 0), rnd(), rnd(), "jalr_adr");
                push(ov(0, 0, 0, 0, 1, 0, OLD, FOUR, ADD, AOUT, 0, 0), rnd(), rnd(), "jump");
                writeback();
            end
            default: ;
        endcase
        play();
    endtask

    // An undecodable opcode parks in TRAP until a one-edge reset brings the core back to FETCH.
    task automatic trap_run(input logic [6:0] op);
        opcode = op;
        fetch(0);
        for (int i = 0; i < 20; i++)
            push(ov(0, 0, 0, 0, 0, 0, PC, RS2, FN, AOUT, 0, 1), rnd(), rnd(), "trap");
        play();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #3;
        chk(16'h0, "trap_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 7'h0;
        mem_ready = 1'b1;
        br_taken  = 1'b1;
        @(posedge clk);
        #1;
        #3;
        chk(16'h0, "reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        instr(K_R, 0, 0, 1'b0);
        instr(K_LD, 0, 3, 1'b0);
        instr(K_BR, 0, 0, 1'b1);
        instr(K_BR, 0, 0, 1'b0);
        instr(K_ST, 1, 2, 1'b0);
        opcode = ops[K_ST];
        fetch(0);
        push(ov(0, 0, 0, 0, 0, 0, RS1, IMM, ADD, AOUT, 0, 0), rnd(), rnd(), "mem_adr");
        push(ov(1, 1, 1, 0, 0, 0, PC, RS2, FN, AOUT, 0, 0), 1'b0, rnd(), "mem_wr_wait");
        play();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #3;
        chk(16'h0, "reset_in_mem_wr");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        #3;
        chk(ov(1, 0, 0, 0, 0, 0, PC, FOUR, ADD, ALUR, 0, 0), "fetch_after_reset");
        @(posedge clk);
        #1;
`ifdef MCYC_JUMP_EN
        instr(K_JAL, 0, 0, 1'b0);
        instr(K_JALR, 1, 0, 1'b0);
`else
        trap_run(ops[K_JAL]);
        trap_run(ops[K_JALR]);
`endif
        for (int n = 0; n < 40; n++) begin
`ifdef MCYC_JUMP_EN
            instr($urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(0, 3), rnd());
`else
            instr($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 3), rnd());
`endif
        end
        trap_run(7'b0000000);
        instr(K_I, 0, 0, 1'b0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
